// File: rtl/hs32_wb_master_pkg.sv
// rtl/hs32_wb_master_pkg.sv - shared FSM encodings and constants for the HS32 Wishbone master bridge
package hs32_wb_master_pkg;

  typedef enum logic [1:0] {
    WBM_IDLE = 2'd0,
    WBM_BUS  = 2'd1,
    WBM_DONE = 2'd2
  } wbm_state_t;

  localparam logic [3:0]  WBM_SEL_ALL  = 4'hF;
  localparam logic [31:0] WBM_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/hs32_wb_master_if.sv
// rtl/hs32_wb_master_if.sv - Wishbone B4 classic bus signals with master/slave views
interface hs32_wb_master_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  wbm_cyc_o;
  logic                  wbm_stb_o;
  logic                  wbm_we_o;
  logic [3:0]            wbm_sel_o;
  logic [ADDR_WIDTH-1:0] wbm_adr_o;
  logic [31:0]           wbm_dat_o;
  logic [31:0]           wbm_dat_i;
  logic                  wbm_ack_i;
  logic                  wbm_err_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );

endinterface

// File: rtl/hs32_wbm_timeout.sv
// rtl/hs32_wbm_timeout.sv - 16-bit bus watchdog counter with clear, enable and expiry flag
module hs32_wbm_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 16'd0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Expiry is evaluated on the edge that would otherwise start cycle TIMEOUT+1.
  assign expired = (count == LIMIT);

endmodule

// File: rtl/hs32_wb_master.sv
// rtl/hs32_wb_master.sv - bridges one internal HS32 stb/ack transaction onto a Wishbone classic master port
module hs32_wb_master
  import hs32_wb_master_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = WBM_ERR_DATA
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_stb,
  input  logic                    i_rw,
  input  logic [31:0]             i_addr,
  input  logic [31:0]             i_dtw,
  output logic [31:0]             o_dtr,
  output logic                    o_ack,
  output logic                    o_err,
  output logic                    o_busy,
  hs32_wb_master_if.master        wbm
);

  wbm_state_t state, state_next;
  logic       take_req, end_ok, end_err;
  logic       cnt_clear, cnt_en, expired;
  logic       rw_q;

  hs32_wbm_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WBM_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Error beats ack; ack beats timeout expiry on the same edge.
  always_comb begin
    state_next = state;
    take_req   = 1'b0;
    end_ok     = 1'b0;
    end_err    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      WBM_IDLE: begin
        if (i_stb) begin
          take_req   = 1'b1;
          cnt_clear  = 1'b1;
          state_next = WBM_BUS;
        end
      end
      WBM_BUS: begin
        if (wbm.wbm_err_i) begin
          end_err = 1'b1;
        end else if (wbm.wbm_ack_i) begin
          end_ok = 1'b1;
        end else if (expired) begin
          end_err = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
        if (end_ok || end_err) begin
          state_next = WBM_DONE;
        end
      end
      WBM_DONE: state_next = WBM_IDLE;
      default:  state_next = WBM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q          <= 1'b0;
      o_dtr         <= 32'd0;
      o_ack         <= 1'b0;
      o_err         <= 1'b0;
      o_busy        <= 1'b0;
      wbm.wbm_cyc_o <= 1'b0;
      wbm.wbm_stb_o <= 1'b0;
      wbm.wbm_we_o  <= 1'b0;
      wbm.wbm_sel_o <= 4'h0;
      wbm.wbm_adr_o <= '0;
      wbm.wbm_dat_o <= 32'd0;
    end else begin
      o_ack <= 1'b0;
      if (take_req) begin
        rw_q          <= i_rw;
        o_busy        <= 1'b1;
        wbm.wbm_cyc_o <= 1'b1;
        wbm.wbm_stb_o <= 1'b1;
        wbm.wbm_we_o  <= i_rw;
        wbm.wbm_sel_o <= WBM_SEL_ALL;
        wbm.wbm_adr_o <= i_addr[ADDR_WIDTH-1:0];
        wbm.wbm_dat_o <= i_dtw;
      end
      if (end_ok || end_err) begin
        wbm.wbm_cyc_o <= 1'b0;
        wbm.wbm_stb_o <= 1'b0;
        wbm.wbm_we_o  <= 1'b0;
        wbm.wbm_sel_o <= 4'h0;
        o_ack         <= 1'b1;
        o_err         <= end_err;
        if (rw_q) begin
          o_dtr <= 32'd0;
        end else begin
          o_dtr <= end_err ? ERR_DATA : wbm.wbm_dat_i;
        end
      end
      if (state == WBM_DONE) begin
        o_busy <= 1'b0;
        o_err  <= 1'b0;
      end
    end
  end

endmodule
